// File: rtl/dram_pkg.sv
// Shared DRAM port definitions: request encodings, lane geometry and writer state.
package dram_pkg;

  localparam int LANES  = 16;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 8;

  localparam logic [1:0] RDWR_IDLE  = 2'b00;
  localparam logic [1:0] RDWR_READ  = 2'b01;
  localparam logic [1:0] RDWR_WRITE = 2'b10;

  typedef logic [LANES-1:0][ADDR_W-1:0] lane_addr_t;
  typedef logic [LANES-1:0][DATA_W-1:0] lane_data_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT,
    DONE
  } wr_state_t;

endpackage

// File: rtl/lane_ack_tracker.sv
// Tracks which lanes of the outstanding burst have been acknowledged by DRAM.
module lane_ack_tracker #(
  parameter int LANES = dram_pkg::LANES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LANES-1:0] load_mask,
  input  logic             accumulate,
  input  logic [LANES-1:0] dram_valid,
  output logic             burst_complete
);

  logic [LANES-1:0] issued_mask;
  logic [LANES-1:0] ack_mask;

  // Loading a new burst wins over any completion arriving on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_mask <= '0;
      ack_mask    <= '0;
    end else if (load) begin
      issued_mask <= load_mask;
      ack_mask    <= '0;
    end else if (accumulate) begin
      ack_mask <= ack_mask | (dram_valid & issued_mask);
    end
  end

  assign burst_complete = (ack_mask == issued_mask);

endmodule

// File: rtl/ser_out_writer.sv
// Packs the serializer byte stream into LANES-wide DRAM write bursts at descending addresses.
module ser_out_writer
  import dram_pkg::*;
#(
  parameter int LANES  = dram_pkg::LANES,
  parameter int ADDR_W = dram_pkg::ADDR_W,
  parameter int DATA_W = dram_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_byte,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [LANES-1:0]              dram_en,
  output logic [1:0]                    dram_rdwr,
  output logic [LANES-1:0][ADDR_W-1:0]  dram_addr,
  output logic [LANES-1:0][DATA_W-1:0]  data_to_dram,
  input  logic [LANES-1:0]              dram_valid,
  output logic [ADDR_W-1:0]             bytes_written,
  output logic                          done
);

  localparam int FILL_W = $clog2(LANES + 1);
  localparam int IDX_W  = $clog2(LANES);

  wr_state_t         state, state_nxt;
  logic [FILL_W-1:0] fill;
  logic [ADDR_W-1:0] cur_addr;
  logic              burst_last;
  logic [DATA_W-1:0] lane_buf [LANES];
  logic [LANES-1:0]  fill_mask;
  logic              burst_complete;
  logic              accept;

  assign accept = (state == FILL) && in_valid;

  always_comb begin
    fill_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(fill)) fill_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    dram_en      = '0;
    dram_rdwr    = RDWR_IDLE;
    dram_addr    = '0;
    data_to_dram = '0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || fill == FILL_W'(LANES - 1))) state_nxt = ISSUE;
      end
      ISSUE: begin
        dram_en   = fill_mask;
        dram_rdwr = RDWR_WRITE;
        for (int i = 0; i < LANES; i++) begin
          dram_addr[i]    = cur_addr - ADDR_W'(i);
          data_to_dram[i] = fill_mask[i] ? lane_buf[i] : '0;
        end
        state_nxt = WAIT;
      end
      WAIT: begin
        if (burst_complete) state_nxt = burst_last ? DONE : FILL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping; cur_addr is pure datapath and is reloaded on every start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill          <= '0;
      bytes_written <= '0;
      burst_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr      <= base_addr;
            bytes_written <= '0;
            fill          <= '0;
            burst_last    <= 1'b0;
          end
        end
        FILL: begin
          if (in_valid) begin
            fill <= fill + FILL_W'(1);
            if (in_last) burst_last <= 1'b1;
          end
        end
        WAIT: begin
          if (burst_complete) begin
            bytes_written <= bytes_written + ADDR_W'(fill);
            cur_addr      <= cur_addr - ADDR_W'(fill);
            fill          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) lane_buf[fill[IDX_W-1:0]] <= in_byte;
  end

  lane_ack_tracker #(
    .LANES (LANES)
  ) u_ack (
    .clk            (clk),
    .reset          (reset),
    .load           (state == ISSUE),
    .load_mask      (fill_mask),
    .accumulate     (state == WAIT),
    .dram_valid     (dram_valid),
    .burst_complete (burst_complete)
  );

endmodule

// File: tb/tb_ser_out_writer.sv
// Scoreboard bench for ser_out_writer: random streams, a DRAM ack model and a burst-level reference.
`timescale 1ns/1ps
module tb_ser_out_writer;
  import dram_pkg::*;

  localparam int L  = 16;
  localparam int AW = 64;
  localparam int DW = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [AW-1:0]         base_addr = '0;
  logic                  in_valid = 1'b0;
  logic [DW-1:0]         in_byte = '0;
  logic                  in_last = 1'b0;
  logic                  in_ready;
  logic [L-1:0]          dram_en;
  logic [1:0]            dram_rdwr;
  logic [L-1:0][AW-1:0]  dram_addr;
  logic [L-1:0][DW-1:0]  data_to_dram;
  logic [L-1:0]          dram_valid = '0;
  logic [AW-1:0]         bytes_written;
  logic                  done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [L-1:0]         en;
    logic [L-1:0][AW-1:0] addr;
    logic [L-1:0][DW-1:0] data;
  } burst_t;

  burst_t        exp_q[$];
  logic [AW-1:0] done_q[$];
  int            ack_mode = 0;
  int            pend[L];
  logic [L-1:0]  cur_issued = '0;

  ser_out_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .dram_en       (dram_en),
    .dram_rdwr     (dram_rdwr),
    .dram_addr     (dram_addr),
    .data_to_dram  (data_to_dram),
    .dram_valid    (dram_valid),
    .bytes_written (bytes_written),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: bursts are consecutive 16-byte slices of the stream, burst k starting at base-16k.
  function automatic void model(input logic [AW-1:0] base, input logic [DW-1:0] b[$]);
    int n;
    n = b.size();
    for (int k = 0; k < n; k += L) begin
      burst_t e;
      e.en   = '0;
      e.data = '0;
      for (int i = 0; i < L; i++) begin
        e.addr[i] = base - AW'(k) - AW'(i);
        if (k + i < n) begin
          e.en[i]   = 1'b1;
          e.data[i] = b[k + i];
        end
      end
      exp_q.push_back(e);
    end
    done_q.push_back(AW'(n));
  endfunction

  // Monitor and DRAM responder.
  initial begin
    logic [L-1:0] dv;
    int outst;
    burst_t e;
    for (int i = 0; i < L; i++) pend[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < L; i++) pend[i] = 0;
        cur_issued = '0;
        dram_valid = '0;
      end else begin
        if (done) begin
          if (done_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            chk("bytes_written_at_done", bytes_written, done_q.pop_front());
          end
        end
        outst = 0;
        for (int i = 0; i < L; i++) if (pend[i] > 0) outst++;
        if (outst > 0) chk("in_ready_low_while_acks_pending", in_ready, 0);
        dv = '0;
        if (dram_en != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue actual=%0h required=0", dram_en);
          end else begin
            e = exp_q.pop_front();
            chk("issue_en", dram_en, e.en);
            chk("issue_rdwr", dram_rdwr, RDWR_WRITE);
            for (int i = 0; i < L; i++)
              chk($sformatf("issue_addr_lane%0d", i), dram_addr[i], e.addr[i]);
            chk("issue_data", data_to_dram, e.data);
          end
          cur_issued = dram_en;
          for (int i = 0; i < L; i++) begin
            if (dram_en[i]) begin
              if (ack_mode == 1)      pend[i] = (i < 8) ? 1 : 4;
              else if (ack_mode == 2) pend[i] = 2;
              else                    pend[i] = $urandom_range(1, 5);
            end
          end
          dv = L'($urandom);
        end else begin
          chk("idle_rdwr", dram_rdwr, RDWR_IDLE);
          chk("idle_data", data_to_dram, '0);
          for (int i = 0; i < L; i++) begin
            if (pend[i] > 0) begin
              pend[i]--;
              if (pend[i] == 0) dv[i] = 1'b1;
            end
          end
          if ($urandom_range(0, 3) == 0) dv = dv | (L'($urandom) & ~cur_issued);
          if (ack_mode == 1 && outst == 0) dv[3] = 1'b1;
        end
        dram_valid = dv;
      end
    end
  end

  task automatic send_byte(input logic [DW-1:0] b, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = DW'($urandom);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 500) begin
      failures++;
      $display("FAIL done_timeout actual=pending required=done");
      done_q.delete();
    end
    chk("all_issues_seen", 128'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("idle_after_done_in_ready", in_ready, 0);
  endtask

  task automatic run_txn(input logic [AW-1:0] base, input int n, input int mode,
                         input bit fixed, input logic [DW-1:0] first);
    logic [DW-1:0] b[$];
    for (int k = 0; k < n; k++) b.push_back(fixed ? DW'(first + DW'(k)) : DW'($urandom));
    model(base, b);
    ack_mode  = mode;
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
    base_addr = {$urandom, $urandom};
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 2) == 0) begin
            start     = 1'b1;
            base_addr = {$urandom, $urandom};
          end
          @(negedge clk);
          start = 1'b0;
        end
      end
      send_byte(b[k], k == n - 1);
    end
    wait_done();
  endtask

  task automatic reset_mid_wait();
    logic [DW-1:0] b[$];
    for (int k = 0; k < 20; k++) b.push_back(DW'($urandom));
    model(64'h5000, b);
    ack_mode  = 0;
    start     = 1'b1;
    base_addr = 64'h5000;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) send_byte(b[k], k == 19);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dram_en", dram_en, '0);
    chk("rst_dram_rdwr", dram_rdwr, RDWR_IDLE);
    chk("rst_dram_addr_lane0", dram_addr[0], '0);
    chk("rst_dram_addr_lane15", dram_addr[15], '0);
    chk("rst_data_to_dram", data_to_dram, '0);
    chk("rst_bytes_written", bytes_written, '0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    done_q.delete();
    exp_q.delete();
    in_valid = 1'b1;
    in_byte  = 8'h55;
    in_last  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("post_rst_bytes_written", bytes_written, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_in_ready", in_ready, 0);
    chk("init_dram_en", dram_en, '0);
    chk("init_dram_rdwr", dram_rdwr, RDWR_IDLE);
    chk("init_data_to_dram", data_to_dram, '0);
    chk("init_bytes_written", bytes_written, '0);
    chk("init_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    run_txn(64'h300, 16, 2, 1'b1, 8'h00);
    run_txn(64'h300, 20, 0, 1'b1, 8'h00);
    run_txn(64'h300, 16, 1, 1'b0, 8'h00);
    run_txn(64'h10, 1, 0, 1'b1, 8'hAB);
    run_txn(64'h2, 4, 0, 1'b1, 8'h40);
    run_txn(64'h5, 33, 0, 1'b0, 8'h00);
    reset_mid_wait();
    run_txn(64'h300, 17, 0, 1'b0, 8'h00);
    for (int t = 0; t < 12; t++) begin
      if (t % 3 == 0) run_txn(AW'($urandom_range(0, 40)), $urandom_range(1, 40), 0, 1'b0, 8'h00);
      else            run_txn({$urandom, $urandom}, $urandom_range(1, 40), 0, 1'b0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
